dram_arbiter: RTL and testbench

Sequences and shares the single external DRAM port between the core's MEM-stage data path and the UART loader/dumper in the IO block. Accepts level-held requests from both sides, grants one at a time, drives the DRAM valid/ready handshake, returns read data with a one-cycle done pulse, and flags a sticky error if the DRAM never answers. Sits between data RAM control, IO and the top-level DRAM pins.

---
 rtl/dram_arbiter_pkg.sv | 18 +
 rtl/dram_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_dram_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_arbiter_pkg.sv
// Shared types and constants for the DRAM port arbiter.
package dram_arbiter_pkg;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    // Grant owner encoding; MEM is the reset value of last_grant, so IO wins the first tie.
    localparam logic OWNER_MEM = 1'b0;
    localparam logic OWNER_IO  = 1'b1;

    // Word address width presented on the DRAM pins (byte address bits [28:2]).
    localparam int DRAM_ADDR_W = 27;

endpackage

// File: rtl/dram_arbiter.sv
// Shares the external DRAM port between the core MEM stage and the UART
// loader/dumper. One transaction at a time, round-robin on ties, registered
// outputs throughout, and a watchdog that aborts a transaction the DRAM never answers.
module dram_arbiter
    import dram_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   core_start,
    input  logic                   mem_req,
    input  logic                   mem_we,
    input  logic [31:0]            mem_addr,
    input  logic [31:0]            mem_wdata,
    output logic [31:0]            mem_rdata,
    output logic                   mem_done,
    input  logic                   io_req,
    input  logic                   io_we,
    input  logic [31:0]            io_addr,
    input  logic [31:0]            io_wdata,
    output logic [31:0]            io_rdata,
    output logic                   io_done,
    input  logic [31:0]            dout_dram,
    input  logic                   ready_dram,
    output logic [DRAM_ADDR_W-1:0] addr_dram,
    output logic [31:0]            din_dram,
    output logic                   rw_dram,
    output logic                   valid_dram,
    output logic                   busy,
    output logic                   timeout_err
);

    state_e                 state_q, state_d;
    logic                   last_grant_q, last_grant_d;
    logic                   owner_q, owner_d;
    logic [31:0]            cnt_q, cnt_d;
    logic                   rw_q, rw_d;
    logic [DRAM_ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]            din_q, din_d;
    logic [31:0]            mem_rdata_q, mem_rdata_d;
    logic [31:0]            io_rdata_q, io_rdata_d;
    logic                   mem_done_q, mem_done_d;
    logic                   io_done_q, io_done_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   timeout_q, timeout_d;

    logic                   mem_elig;
    logic                   grant;
    logic                   wd_expired;

    // Byte-lane and high address bits are not part of the DRAM word address.
    logic                   unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[31:29], mem_addr[1:0], io_addr[31:29], io_addr[1:0]};

    // Next-state, arbitration, watchdog and next-output computation.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        din_d        = din_q;
        mem_rdata_d  = mem_rdata_q;
        io_rdata_d   = io_rdata_q;
        mem_done_d   = 1'b0;
        io_done_d    = 1'b0;
        timeout_d    = timeout_q;
        mem_elig     = mem_req && core_start;
        grant        = OWNER_MEM;
        wd_expired   = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_CYCLES - 1);

        case (state_q)
            IDLE: begin
                if (io_req || mem_elig) begin
                    if (io_req && mem_elig) begin
                        grant = (last_grant_q == OWNER_MEM) ? OWNER_IO : OWNER_MEM;
                    end else begin
                        grant = io_req ? OWNER_IO : OWNER_MEM;
                    end
                    owner_d      = grant;
                    last_grant_d = grant;
                    cnt_d        = 32'd0;
                    state_d      = ISSUE;
                    if (grant == OWNER_IO) begin
                        rw_d   = io_we;
                        addr_d = io_addr[28:2];
                        din_d  = io_wdata;
                    end else begin
                        rw_d   = mem_we;
                        addr_d = mem_addr[28:2];
                        din_d  = mem_wdata;
                    end
                end
            end
            ISSUE: begin
                if (ready_dram) begin
                    state_d = RESP;
                    if (!rw_q) begin
                        if (owner_q == OWNER_IO) io_rdata_d = dout_dram;
                        else                     mem_rdata_d = dout_dram;
                    end
                    if (owner_q == OWNER_IO) io_done_d = 1'b1;
                    else                     mem_done_d = 1'b1;
                end else if (wd_expired) begin
                    // DRAM never answered: abort with zero read data and a sticky flag.
                    state_d   = RESP;
                    timeout_d = 1'b1;
                    if (owner_q == OWNER_IO) begin
                        io_rdata_d = 32'd0;
                        io_done_d  = 1'b1;
                    end else begin
                        mem_rdata_d = 32'd0;
                        mem_done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            RESP: begin
                // Requests are not re-sampled here; the requester drops req next cycle.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        valid_d = (state_d == ISSUE);
        busy_d  = (state_d != IDLE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            last_grant_q <= OWNER_MEM;
            owner_q      <= OWNER_MEM;
            cnt_q        <= 32'd0;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            din_q        <= 32'd0;
            mem_rdata_q  <= 32'd0;
            io_rdata_q   <= 32'd0;
            mem_done_q   <= 1'b0;
            io_done_q    <= 1'b0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            mem_rdata_q  <= mem_rdata_d;
            io_rdata_q   <= io_rdata_d;
            mem_done_q   <= mem_done_d;
            io_done_q    <= io_done_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
        end
    end

    assign addr_dram   = addr_q;
    assign din_dram    = din_q;
    assign rw_dram     = rw_q;
    assign valid_dram  = valid_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_q;
    assign mem_rdata   = mem_rdata_q;
    assign mem_done    = mem_done_q;
    assign io_rdata    = io_rdata_q;
    assign io_done     = io_done_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_dram_arbiter;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        core_start = 1'b0;
    logic        mem_req = 1'b0, mem_we = 1'b0;
    logic [31:0] mem_addr = 32'd0, mem_wdata = 32'd0;
    logic        io_req = 1'b0, io_we = 1'b0;
    logic [31:0] io_addr = 32'd0, io_wdata = 32'd0;
    logic [31:0] dout_dram = 32'd0;
    logic        ready_dram = 1'b0;

    logic [31:0] mem_rdata, io_rdata, din_dram;
    logic        mem_done, io_done, rw_dram, valid_dram, busy, timeout_err;
    logic [26:0] addr_dram;

    always #5 clk = ~clk;

    dram_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rstn(rstn), .core_start(core_start),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_done(io_done),
        .dout_dram(dout_dram), .ready_dram(ready_dram),
        .addr_dram(addr_dram), .din_dram(din_dram), .rw_dram(rw_dram),
        .valid_dram(valid_dram), .busy(busy), .timeout_err(timeout_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    logic [31:0] m_mem_rdata = 0, m_io_rdata = 0, m_din = 0;
    logic [26:0] m_addr = 0;
    logic        m_rw = 0, m_valid = 0, m_busy = 0, m_mem_done = 0, m_io_done = 0, m_tmo = 0;
    bit          m_active = 0, m_cool = 0, m_last_io = 0, m_owner_io = 0;
    bit          m_e_io, m_e_mem, m_pick_io;
    int          m_age = 0;

    initial forever begin
        @(posedge clk or negedge rstn);
        if (!rstn) begin
            m_mem_rdata = 0; m_io_rdata = 0; m_din = 0; m_addr = 0; m_rw = 0;
            m_valid = 0; m_busy = 0; m_mem_done = 0; m_io_done = 0; m_tmo = 0;
            m_active = 0; m_cool = 0; m_last_io = 0; m_owner_io = 0; m_age = 0;
        end else begin
            m_mem_done = 0;
            m_io_done  = 0;
            if (m_cool) begin
                m_cool = 0;
            end else if (m_active) begin
                m_age++;
                if (ready_dram || m_age == int'(TMO)) begin
                    m_active = 0;
                    m_cool   = 1;
                    if (!ready_dram) begin
                        m_tmo = 1;
                        if (m_owner_io) m_io_rdata = 0; else m_mem_rdata = 0;
                    end else if (!m_rw) begin
                        if (m_owner_io) m_io_rdata = dout_dram; else m_mem_rdata = dout_dram;
                    end
                    if (m_owner_io) m_io_done = 1; else m_mem_done = 1;
                end
            end else begin
                m_e_io  = io_req;
                m_e_mem = mem_req && core_start;
                if (m_e_io || m_e_mem) begin
                    m_pick_io  = (m_e_io && m_e_mem) ? !m_last_io : m_e_io;
                    m_owner_io = m_pick_io;
                    m_last_io  = m_pick_io;
                    m_rw   = m_pick_io ? io_we : mem_we;
                    m_addr = 27'((m_pick_io ? io_addr : mem_addr) >> 2);
                    m_din  = m_pick_io ? io_wdata : mem_wdata;
                    m_active = 1;
                    m_age    = 0;
                end
            end
            m_valid = m_active;
            m_busy  = m_active || m_cool;
        end
    end

    // ---------------- per-cycle compare + monitors ----------------
    bit done_log[$];
    int vrun = 0;
    int last_vlen = 0;

    initial forever begin
        @(negedge clk);
        check("valid_dram", valid_dram, m_valid);
        check("busy", busy, m_busy);
        check("mem_done", mem_done, m_mem_done);
        check("io_done", io_done, m_io_done);
        check("mem_rdata", mem_rdata, m_mem_rdata);
        check("io_rdata", io_rdata, m_io_rdata);
        check("timeout_err", timeout_err, m_tmo);
        if (m_valid) begin
            check("rw_dram", rw_dram, m_rw);
            check("addr_dram", addr_dram, m_addr);
            check("din_dram", din_dram, m_din);
        end
        if (valid_dram) vrun++;
        else if (vrun > 0) begin last_vlen = vrun; vrun = 0; end
        if (io_done)  done_log.push_back(1'b1);
        if (mem_done) done_log.push_back(1'b0);
    end

    // ---------------- requester agents ----------------
    int          io_todo = 0, mem_todo = 0;
    bit          rand_params = 0;
    bit          io_drop = 0, mem_drop = 0;
    logic        io_fix_we = 0, mem_fix_we = 0;
    logic [31:0] io_fix_addr = 0, io_fix_wdata = 0, mem_fix_addr = 0, mem_fix_wdata = 0;

    initial forever begin
        @(posedge clk);
        #1;
        if (!rstn) begin
            io_req = 0; io_drop = 0; mem_req = 0; mem_drop = 0;
        end else begin
            if (io_drop) begin
                io_req = 0; io_drop = 0;
            end else if (io_req && io_done) begin
                io_drop = 1;
            end else if (!io_req && io_todo > 0) begin
                io_req = 1; io_todo--;
                if (rand_params) begin
                    io_we = 1'($urandom_range(0, 1)); io_addr = $urandom; io_wdata = $urandom;
                end else begin
                    io_we = io_fix_we; io_addr = io_fix_addr; io_wdata = io_fix_wdata;
                end
            end
            if (mem_drop) begin
                mem_req = 0; mem_drop = 0;
            end else if (mem_req && mem_done) begin
                mem_drop = 1;
            end else if (!mem_req && mem_todo > 0) begin
                mem_req = 1; mem_todo--;
                if (rand_params) begin
                    mem_we = 1'($urandom_range(0, 1)); mem_addr = $urandom; mem_wdata = $urandom;
                end else begin
                    mem_we = mem_fix_we; mem_addr = mem_fix_addr; mem_wdata = mem_fix_wdata;
                end
            end
        end
    end

    // ---------------- DRAM responder (0=silent, 1=fixed delay, 2=random) ----------------
    int          resp_mode = 1, fix_delay = 1, vcnt = 0, cur_delay = 1;
    logic [31:0] dout_fix = 0;

    initial forever begin
        @(posedge clk);
        #1;
        ready_dram = 0;
        if (valid_dram) begin
            vcnt++;
            if (resp_mode != 0 && vcnt >= cur_delay) begin
                ready_dram = 1;
                dout_dram  = (resp_mode == 1) ? dout_fix : $urandom;
            end
        end else begin
            vcnt = 0;
            cur_delay = (resp_mode == 2) ? int'($urandom_range(1, 8)) : fix_delay;
            if (resp_mode == 2 && $urandom_range(0, 7) == 0) begin
                ready_dram = 1;
                dout_dram  = $urandom;
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_valid(input string name);
        int k = 0;
        while (!valid_dram && k < 50) begin @(negedge clk); #1; k++; end
        if (!valid_dram) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: valid_dram got 0 expected 1 within 50 cycles", name);
        end
    endtask

    task automatic wait_dones(input int n, input string name);
        int k = 0;
        while (done_log.size() < n && k < 200) begin @(negedge clk); #1; k++; end
        if (done_log.size() < n) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: completions got %0d expected %0d within 200 cycles", name, done_log.size(), n);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rstn = 0;
        repeat (2) @(negedge clk);
        #1 rstn = 1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        #2 rstn = 0;
        #1;
        // Reset state
        check("rst_valid", valid_dram, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", addr_dram, 0);
        check("rst_tmo", timeout_err, 0);
        #19 rstn = 1;

        // IO write 0x10 / 0xA5A55A5A, DRAM answers 3 cycles into ISSUE
        resp_mode = 1; fix_delay = 3;
        io_fix_we = 1; io_fix_addr = 32'h0000_0010; io_fix_wdata = 32'hA5A5_5A5A;
        @(negedge clk); #1;
        done_log.delete();
        io_todo = 1;
        wait_valid("t_io_wr");
        check("t_io_wr_addr", addr_dram, 32'h4);
        check("t_io_wr_rw", rw_dram, 1);
        check("t_io_wr_din", din_dram, 32'hA5A5_5A5A);
        wait_dones(1, "t_io_wr");
        check("t_io_wr_iodone", io_done, 1);
        check("t_io_wr_memdone", mem_done, 0);
        check("t_io_wr_vlen", last_vlen, 3);
        @(negedge clk); #1;
        check("t_io_wr_iodone_pulse", io_done, 0);
        repeat (3) @(negedge clk);

        // MEM read 0x100 returning 0x12345678
        core_start = 1; fix_delay = 1; dout_fix = 32'h1234_5678;
        mem_fix_we = 0; mem_fix_addr = 32'h0000_0100;
        #1 done_log.delete();
        mem_todo = 1;
        wait_valid("t_mem_rd");
        check("t_mem_rd_addr", addr_dram, 32'h40);
        check("t_mem_rd_rw", rw_dram, 0);
        wait_dones(1, "t_mem_rd");
        check("t_mem_rd_done", mem_done, 1);
        check("t_mem_rd_rdata", mem_rdata, 32'h1234_5678);
        check("t_mem_rd_iordata", io_rdata, 0);
        repeat (3) @(negedge clk);

        // mem_req ignored while core_start is low
        core_start = 0;
        mem_fix_we = 1; mem_fix_addr = 32'h0000_0200; mem_fix_wdata = 32'h55;
        #1 done_log.delete();
        mem_todo = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            check("t_nostart_valid", valid_dram, 0);
            check("t_nostart_busy", busy, 0);
        end
        core_start = 1;
        wait_dones(1, "t_nostart");
        check("t_nostart_done", mem_done, 1);
        check("t_nostart_rdata_kept", mem_rdata, 32'h1234_5678);
        repeat (3) @(negedge clk);

        // Simultaneous requests after reset alternate IO, MEM, ...
        do_reset();
        io_fix_we = 0; io_fix_addr = 32'h20; mem_fix_we = 0; mem_fix_addr = 32'h40;
        dout_fix = 32'hDEAD_BEEF;
        done_log.delete();
        for (int r = 0; r < 3; r++) begin
            @(negedge clk); #1;
            io_todo = 1; mem_todo = 1;
            wait_dones(2 * (r + 1), "t_rr");
            repeat (3) @(negedge clk);
        end
        check("t_rr_count", done_log.size(), 6);
        for (int i = 0; i < done_log.size() && i < 6; i++)
            check($sformatf("t_rr_order%0d", i), done_log[i], (i % 2 == 0) ? 1 : 0);
        check("t_rr_iordata", io_rdata, 32'hDEAD_BEEF);

        // Watchdog: DRAM silent, abort after TMO ISSUE cycles
        resp_mode = 0;
        io_fix_we = 0; io_fix_addr = 32'h30;
        #1 done_log.delete();
        io_todo = 1;
        wait_dones(1, "t_tmo");
        check("t_tmo_done", io_done, 1);
        check("t_tmo_rdata", io_rdata, 0);
        check("t_tmo_err", timeout_err, 1);
        check("t_tmo_vlen", last_vlen, 8);
        repeat (10) @(negedge clk);
        #1;
        check("t_tmo_sticky", timeout_err, 1);
        check("t_tmo_idle", busy, 0);

        // Reset in the middle of ISSUE
        io_fix_we = 1; io_fix_addr = 32'h44; io_fix_wdata = 32'h77;
        io_todo = 1;
        wait_valid("t_midrst");
        rstn = 0;
        #1;
        check("t_midrst_valid", valid_dram, 0);
        check("t_midrst_busy", busy, 0);
        check("t_midrst_rw", rw_dram, 0);
        check("t_midrst_addr", addr_dram, 0);
        check("t_midrst_din", din_dram, 0);
        check("t_midrst_iordata", io_rdata, 0);
        check("t_midrst_memrdata", mem_rdata, 0);
        check("t_midrst_tmo", timeout_err, 0);
        repeat (2) @(negedge clk);
        #1 rstn = 1;
        resp_mode = 1; fix_delay = 2; dout_fix = 32'h0BAD_F00D;
        mem_fix_we = 0; mem_fix_addr = 32'h80;
        done_log.delete();
        mem_todo = 1;
        wait_dones(1, "t_postrst");
        check("t_postrst_done", mem_done, 1);
        check("t_postrst_rdata", mem_rdata, 32'h0BAD_F00D);
        check("t_postrst_vlen", last_vlen, 2);
        check("t_postrst_tmo", timeout_err, 0);
        repeat (3) @(negedge clk);

        // Randomized traffic checked every cycle by the model
        rand_params = 1; resp_mode = 2;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            if (io_todo == 0 && !io_req && $urandom_range(0, 3) == 0) io_todo = 1;
            if (mem_todo == 0 && !mem_req && $urandom_range(0, 3) == 0) mem_todo = 1;
            if ($urandom_range(0, 9) == 0) core_start = ~core_start;
        end
        io_todo = 0; mem_todo = 0; core_start = 1;
        repeat (30) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
